rf_access_ctrl: RTL

Scheduler in front of the 32x32 register file in the decode stage. It owns the register file's read-enable, write-enable and address ports. It arbitrates the single write port between ALU and LSU writeback with round-robin priority. A pending-write scoreboard stalls decode issue on RAW/WAW hazards.

---
 rtl/rf_access_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/rf_access_ctrl.sv
// Decode-stage register file scheduler: read-port enables, round-robin ALU/LSU
// write-port arbitration and a pending-write scoreboard that stalls on RAW/WAW.
module rf_access_ctrl #(
  parameter int NBITS      = 32,
  parameter int NREGISTERS = 32,
  parameter int AW         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic             iss_rs1_used,
  input  logic             iss_rs2_used,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_rd_used,
  input  logic             alu_wb_valid,
  output logic             alu_wb_ready,
  input  logic [AW-1:0]    alu_wb_rd,
  input  logic [NBITS-1:0] alu_wb_data,
  input  logic             lsu_wb_valid,
  output logic             lsu_wb_ready,
  input  logic [AW-1:0]    lsu_wb_rd,
  input  logic [NBITS-1:0] lsu_wb_data,
  output logic             rf_rd1_en,
  output logic             rf_rd2_en,
  output logic [AW-1:0]    rf_add_rd1,
  output logic [AW-1:0]    rf_add_rd2,
  output logic             rf_wr_en,
  output logic [AW-1:0]    rf_add_wr,
  output logic [NBITS-1:0] rf_datain,
  output logic [5:0]       pend_cnt
);

  localparam logic RR_ALU = 1'b0;
  localparam logic RR_LSU = 1'b1;
  localparam logic [NREGISTERS-1:0] ONE_HOT0 = {{(NREGISTERS-1){1'b0}}, 1'b1};

  logic [NREGISTERS-1:0] r_pend;
  logic [5:0]            r_pend_cnt;
  logic                  r_rr_last;

  logic                  w_hz;
  logic                  w_alu_gnt;
  logic                  w_lsu_gnt;
  logic                  w_set;
  logic                  w_clr;
  logic                  w_dec;
  logic [NREGISTERS-1:0] w_set_mask;
  logic [NREGISTERS-1:0] w_clr_mask;

  // x0 is masked explicitly so it can never produce a hazard
  assign w_hz = (iss_rs1_used & (iss_rs1 != {AW{1'b0}}) & r_pend[iss_rs1]) |
                (iss_rs2_used & (iss_rs2 != {AW{1'b0}}) & r_pend[iss_rs2]) |
                (iss_rd_used  & (iss_rd  != {AW{1'b0}}) & r_pend[iss_rd]);

  assign iss_ready  = iss_valid & ~w_hz & ~flush & ~rst;
  assign rf_rd1_en  = iss_ready & iss_rs1_used;
  assign rf_rd2_en  = iss_ready & iss_rs2_used;
  assign rf_add_rd1 = rf_rd1_en ? iss_rs1 : {AW{1'b0}};
  assign rf_add_rd2 = rf_rd2_en ? iss_rs2 : {AW{1'b0}};

  // On a tie the requester that was not granted last wins
  assign w_alu_gnt = ~rst & alu_wb_valid & (~lsu_wb_valid | (r_rr_last == RR_LSU));
  assign w_lsu_gnt = ~rst & lsu_wb_valid & (~alu_wb_valid | (r_rr_last == RR_ALU));

  assign alu_wb_ready = w_alu_gnt;
  assign lsu_wb_ready = w_lsu_gnt;

  assign rf_add_wr = w_alu_gnt ? alu_wb_rd   : (w_lsu_gnt ? lsu_wb_rd   : {AW{1'b0}});
  assign rf_datain = w_alu_gnt ? alu_wb_data : (w_lsu_gnt ? lsu_wb_data : {NBITS{1'b0}});
  assign rf_wr_en  = (w_alu_gnt | w_lsu_gnt) & (rf_add_wr != {AW{1'b0}});

  assign w_set      = iss_ready & iss_rd_used & (iss_rd != {AW{1'b0}});
  assign w_clr      = rf_wr_en;
  assign w_set_mask = w_set ? (ONE_HOT0 << iss_rd)    : {NREGISTERS{1'b0}};
  assign w_clr_mask = w_clr ? (ONE_HOT0 << rf_add_wr) : {NREGISTERS{1'b0}};
  // Only count a clear that actually drops a set bit; a same-edge set of that bit wins
  assign w_dec      = w_clr & r_pend[rf_add_wr] & ~(w_set & (iss_rd == rf_add_wr));

  assign pend_cnt = r_pend_cnt;

  // Scoreboard, pending count and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= {NREGISTERS{1'b0}};
      r_pend_cnt <= 6'd0;
      r_rr_last  <= RR_LSU;
    end else begin
      if (flush) begin
        r_pend     <= {NREGISTERS{1'b0}};
        r_pend_cnt <= 6'd0;
      end else begin
        r_pend     <= (r_pend & ~w_clr_mask) | w_set_mask;
        r_pend_cnt <= r_pend_cnt + {5'd0, w_set} - {5'd0, w_dec};
      end
      if (w_alu_gnt) begin
        r_rr_last <= RR_ALU;
      end else if (w_lsu_gnt) begin
        r_rr_last <= RR_LSU;
      end else begin
        r_rr_last <= r_rr_last;
      end
    end
  end

endmodule
